// File: rtl/sfu_operand_fifo.sv
// sfu_operand_fifo
// Operand buffer feeding the SFU controller. Issue logic pushes operands,
// the controller pops one entry per cycle through re_i; the popped operand is
// presented on rd_data one cycle later, qualified by the validi strobe.
// Occupancy is tracked by an explicit counter, which alone decides full/empty;
// the read/write pointers wrap freely at AW bits.
//
// Optional feature macro: SFU_FIFO_ERR_CNT_EN
//   When defined, adds saturating 8-bit counters ovf_cnt (pushes dropped while
//   full) and udf_cnt (pops rejected while empty). When undefined the ports and
//   the counter logic are absent and the core behaviour is unchanged.
module sfu_operand_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int AFULL = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  input  logic          re_i,
  output logic [DW-1:0] rd_data,
  output logic          validi,
  output logic          empty,
  output logic [AW:0]   count
`ifdef SFU_FIFO_ERR_CNT_EN
  ,
  output logic [7:0]    ovf_cnt,
  output logic [7:0]    udf_cnt
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   count_nxt;

  // Accept decisions use the registered flags from before the edge.
  assign push_ok = wr_en && !full;
  assign pop_ok  = re_i && !empty;

  // Next occupancy; flags are derived from this so they match count every cycle.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Control state: pointers, occupancy, registered flags and the read strobe.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      validi      <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AFULL_C);
      validi      <= pop_ok;
    end
  end

  // Storage is never reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wptr] <= wr_data;
  end

  // Registered read port: cleared by rst, held across flush and rejected pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!flush && pop_ok) begin
      rd_data <= mem[rptr];
    end
  end

`ifdef SFU_FIFO_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating error counters for dropped pushes and rejected pops.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_en && full) ovf_cnt <= sat_inc(ovf_cnt);
      if (re_i && empty) udf_cnt <= sat_inc(udf_cnt);
    end
  end
`endif

endmodule
